// File: rtl/y86_pipe_ctrl_pkg.sv
// Shared Y86 icode/stat/register encodings and the pipeline-control FSM states.
package y86_pipe_ctrl_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [3:0] S_OK  = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    localparam logic [3:0] R_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

endpackage

// File: rtl/y86_pipe_ctrl_hazard_det.sv
// Combinational hazard terms: load/use, ret in flight, branch mispredict,
// pending exception, and whether the M-stage instruction touches data memory.
module y86_hazard_det
    import y86_pipe_ctrl_pkg::*;
(
    input  logic [3:0] i_D_icode,
    input  logic [3:0] i_d_srcA,
    input  logic [3:0] i_d_srcB,
    input  logic [3:0] i_E_icode,
    input  logic [3:0] i_E_dstM,
    input  logic       i_e_Cnd,
    input  logic [3:0] i_M_icode,
    input  logic [3:0] i_M_stat,
    input  logic [3:0] i_W_stat,
    output logic       o_lu,
    output logic       o_rt,
    output logic       o_mp,
    output logic       o_exc,
    output logic       o_memop
);

    logic w_e_is_load;

    assign w_e_is_load = (i_E_icode == I_MRMOVL) || (i_E_icode == I_POPL);
    assign o_lu  = w_e_is_load && (i_E_dstM != R_NONE) &&
                   ((i_E_dstM == i_d_srcA) || (i_E_dstM == i_d_srcB));
    assign o_rt  = (i_D_icode == I_RET) || (i_E_icode == I_RET) || (i_M_icode == I_RET);
    assign o_mp  = (i_E_icode == I_JXX) && !i_e_Cnd;
    assign o_exc = (i_M_stat != S_OK) || (i_W_stat != S_OK);
    assign o_memop = (i_M_icode == I_RMMOVL) || (i_M_icode == I_MRMOVL) ||
                     (i_M_icode == I_CALL)   || (i_M_icode == I_RET)    ||
                     (i_M_icode == I_PUSHL)  || (i_M_icode == I_POPL);

endmodule

// File: rtl/y86_pipe_ctrl.sv
// Pipeline control: stall/bubble strobes from hazards, data-memory wait FSM
// with timeout, terminal halt, and saturating stall/bubble counters.
module y86_pipe_ctrl
    import y86_pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       M_stat,
    input  logic [3:0]       W_stat,
    input  logic             dmem_ack,
    output logic             F_stall,
    output logic             D_stall,
    output logic             E_stall,
    output logic             M_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_bubble,
    output logic             dmem_req,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    state_t            r_state, w_state_nxt;
    logic [WC_W-1:0]   r_wait_cnt, w_wait_nxt, w_wait_inc;
    logic              r_mem_err, w_err_set;
    logic [CNT_W-1:0]  r_stall_cnt, r_bubble_cnt;
    logic              w_lu, w_rt, w_mp, w_exc, w_memop;

    y86_hazard_det u_hazard (
        .i_D_icode (D_icode),
        .i_d_srcA  (d_srcA),
        .i_d_srcB  (d_srcB),
        .i_E_icode (E_icode),
        .i_E_dstM  (E_dstM),
        .i_e_Cnd   (e_Cnd),
        .i_M_icode (M_icode),
        .i_M_stat  (M_stat),
        .i_W_stat  (W_stat),
        .o_lu      (w_lu),
        .o_rt      (w_rt),
        .o_mp      (w_mp),
        .o_exc     (w_exc),
        .o_memop   (w_memop)
    );

    assign w_wait_inc = r_wait_cnt + WC_W'(1);

    always_comb begin
        F_stall = 1'b0; D_stall = 1'b0; E_stall = 1'b0; M_stall = 1'b0; W_stall = 1'b0;
        D_bubble = 1'b0; E_bubble = 1'b0; M_bubble = 1'b0; W_bubble = 1'b0;
        halted = 1'b0;
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_err_set   = 1'b0;
        dmem_req = w_memop && !w_exc && (r_state != ST_HALTED);

        case (r_state)
            ST_RUN, ST_MEM_WAIT: begin
                if ((r_state == ST_MEM_WAIT || dmem_req) && !dmem_ack) begin
                    // Freeze F..M and drain W while the access is outstanding.
                    F_stall = 1'b1; D_stall = 1'b1; E_stall = 1'b1; M_stall = 1'b1;
                    W_bubble = 1'b1;
                    if (r_state == ST_RUN) begin
                        w_state_nxt = ST_MEM_WAIT;
                        w_wait_nxt  = '0;
                    end else if (w_wait_inc == WC_W'(MEM_TIMEOUT - 1)) begin
                        w_state_nxt = ST_HALTED;
                        w_wait_nxt  = '0;
                        w_err_set   = 1'b1;
                    end else begin
                        w_wait_nxt = w_wait_inc;
                    end
                end else begin
                    F_stall  = w_lu || w_rt;
                    D_stall  = w_lu;
                    D_bubble = w_mp || (w_rt && !w_lu);
                    E_bubble = w_mp || w_lu;
                    M_bubble = w_exc;
                    W_stall  = (W_stat != S_OK);
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                end
            end
            ST_HALTED: begin
                F_stall = 1'b1; D_stall = 1'b1; E_stall = 1'b1; M_stall = 1'b1; W_stall = 1'b1;
                halted = 1'b1;
            end
            default: w_state_nxt = ST_RUN;
        endcase

        if (W_stat != S_OK) begin
            w_state_nxt = ST_HALTED;
            w_wait_nxt  = '0;
        end

        if (reset) begin
            F_stall = 1'b0; D_stall = 1'b0; E_stall = 1'b0; M_stall = 1'b0; W_stall = 1'b0;
            D_bubble = 1'b0; E_bubble = 1'b0; M_bubble = 1'b0; W_bubble = 1'b0;
            dmem_req = 1'b0;
            halted   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_wait_cnt   <= '0;
            r_mem_err    <= 1'b0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_err_set)
                r_mem_err <= 1'b1;
            if (F_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if ((D_bubble || E_bubble || M_bubble || W_bubble) && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign mem_err    = r_mem_err;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// Randomized and directed bench for y86_pipe_ctrl against a cycle-level behavioural model.
module tb_y86_pipe_ctrl;

    localparam int TO    = 4;
    localparam int CNT_W = 6;
    localparam longint MAXC = (64'd1 << CNT_W) - 1;

    typedef struct packed {
        logic f_s, d_s, e_s, m_s, w_s, d_b, e_b, m_b, w_b, req, hlt, err;
    } outs_t;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, M_stat, W_stat;
    logic e_Cnd, dmem_ack;
    logic F_stall, D_stall, E_stall, M_stall, W_stall;
    logic D_bubble, E_bubble, M_bubble, W_bubble, dmem_req, halted, mem_err;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: mode 0 = running, 1 = waiting on memory, 2 = halted
    int     m_mode = 0;
    int     m_wait = 0;
    bit     m_err  = 0;
    longint m_stall = 0;
    longint m_bub   = 0;

    outs_t obs, ex;

    always #5 clk = ~clk;

    y86_pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .M_stat(M_stat), .W_stat(W_stat), .dmem_ack(dmem_ack),
        .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall),
        .W_stall(W_stall), .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .W_bubble(W_bubble), .dmem_req(dmem_req), .halted(halted), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    assign obs = '{F_stall, D_stall, E_stall, M_stall, W_stall, D_bubble, E_bubble,
                   M_bubble, W_bubble, dmem_req, halted, mem_err};

    function automatic outs_t model_out();
        outs_t o = '0;
        bit memop, exc, lu, rt, mp;
        memop = M_icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        exc   = (M_stat != 4'h1) || (W_stat != 4'h1);
        lu    = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
                (E_dstM == d_srcA || E_dstM == d_srcB);
        rt    = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
        mp    = (E_icode == 4'h7) && !e_Cnd;
        o.err = m_err;
        if (reset) return o;
        o.req = memop && !exc && (m_mode != 2);
        if (m_mode == 2) begin
            {o.f_s, o.d_s, o.e_s, o.m_s, o.w_s} = 5'b11111;
            o.hlt = 1'b1;
        end else if ((m_mode == 1 || o.req) && !dmem_ack) begin
            {o.f_s, o.d_s, o.e_s, o.m_s, o.w_b} = 5'b11111;
        end else begin
            o.f_s = lu || rt;
            o.d_s = lu;
            o.d_b = mp || (rt && !lu);
            o.e_b = mp || lu;
            o.m_b = exc;
            o.w_s = (W_stat != 4'h1);
        end
        return o;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_clock();
        outs_t o;
        o = model_out();
        if (reset) begin
            m_mode = 0; m_wait = 0; m_err = 0; m_stall = 0; m_bub = 0;
            return;
        end
        if (o.f_s && m_stall < MAXC) m_stall++;
        if ((o.d_b || o.e_b || o.m_b || o.w_b) && m_bub < MAXC) m_bub++;
        if (W_stat != 4'h1) begin
            m_mode = 2; m_wait = 0;
        end else if (m_mode == 0) begin
            if (o.req && !dmem_ack) begin m_mode = 1; m_wait = 0; end
        end else if (m_mode == 1) begin
            if (dmem_ack) begin
                m_mode = 0; m_wait = 0;
            end else if (m_wait + 1 == TO - 1) begin
                m_mode = 2; m_wait = 0; m_err = 1;
            end else begin
                m_wait++;
            end
        end
    endtask

    task automatic set_idle();
        reset = 1'b0;
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
        e_Cnd = 1'b1; M_stat = 4'h1; W_stat = 4'h1; dmem_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            reset = 1'b1;
            M_icode = 4'h5; W_stat = 4'h1; dmem_ack = 1'b0;
            E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2; D_icode = 4'h9;
            #2; ex = model_out();
            n_checks++;
            if (obs !== ex) begin
                n_errors++; $display("FAIL reset_outs cyc%0d: got %b want %b", i, obs, ex);
            end
            tick();
            n_checks++;
            if (stall_cnt !== '0 || bubble_cnt !== '0 || mem_err !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_regs cyc%0d: got %0d/%0d/%b want 0/0/0", i, stall_cnt, bubble_cnt, mem_err);
            end
        end
        set_idle();
    endtask

    task automatic test_load_use();
        do_reset();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #2; ex = model_out();
        n_checks++;
        if (obs !== ex || {F_stall, D_stall, E_bubble, D_bubble} !== 4'b1110) begin
            n_errors++; $display("FAIL load_use: got %b want %b", obs, ex);
        end
        tick();
        n_checks++;
        if (stall_cnt !== CNT_W'(1) || bubble_cnt !== CNT_W'(1)) begin
            n_errors++; $display("FAIL load_use_cnt: got %0d/%0d want 1/1", stall_cnt, bubble_cnt);
        end
        // load/use together with ret in D
        D_icode = 4'h9;
        #2; ex = model_out();
        n_checks++;
        if (obs !== ex) begin
            n_errors++; $display("FAIL lu_ret: got %b want %b", obs, ex);
        end
        tick();
        set_idle();
    endtask

    task automatic test_ret();
        do_reset();
        D_icode = 4'h9;
        for (int i = 0; i < 3; i++) begin
            #2; ex = model_out();
            n_checks++;
            if (obs !== ex || {F_stall, D_bubble, E_bubble} !== 3'b110) begin
                n_errors++; $display("FAIL ret cyc%0d: got %b want %b", i, obs, ex);
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_mispredict();
        do_reset();
        E_icode = 4'h7; e_Cnd = 1'b0;
        #2; ex = model_out();
        n_checks++;
        if (obs !== ex || {D_bubble, E_bubble, F_stall} !== 3'b110) begin
            n_errors++; $display("FAIL mispredict: got %b want %b", obs, ex);
        end
        tick();
        D_icode = 4'h9;
        #2; ex = model_out();
        n_checks++;
        if (obs !== ex) begin
            n_errors++; $display("FAIL mp_ret: got %b want %b", obs, ex);
        end
        tick();
        set_idle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        M_icode = 4'h5;
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            #2; ex = model_out();
            n_checks++;
            if (obs !== ex || dmem_req !== 1'b1) begin
                n_errors++; $display("FAIL mem_wait cyc%0d: got %b want %b", i, obs, ex);
            end
            tick();
        end
        dmem_ack = 1'b0; M_icode = 4'h1;
        #2; ex = model_out();
        n_checks++;
        if (obs !== ex) begin
            n_errors++; $display("FAIL mem_wait_after: got %b want %b", obs, ex);
        end
        set_idle();
    endtask

    task automatic test_timeout();
        do_reset();
        M_icode = 4'h4; dmem_ack = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #2; ex = model_out();
            n_checks++;
            if (obs !== ex) begin
                n_errors++; $display("FAIL timeout cyc%0d: got %b want %b", i, obs, ex);
            end
            tick();
        end
        n_checks++;
        if ({mem_err, halted, F_stall, D_stall, E_stall, M_stall, W_stall} !== 7'h7F) begin
            n_errors++; $display("FAIL timeout_halt: got %b want 1111111",
                {mem_err, halted, F_stall, D_stall, E_stall, M_stall, W_stall});
        end
        do_reset();
        #2; ex = model_out();
        n_checks++;
        if (obs !== ex || obs !== '0) begin
            n_errors++; $display("FAIL timeout_reset: got %b want %b", obs, ex);
        end
        set_idle();
    endtask

    task automatic test_exception();
        do_reset();
        M_icode = 4'h5; M_stat = 4'h3;
        #2; ex = model_out();
        n_checks++;
        if (obs !== ex || M_bubble !== 1'b1 || dmem_req !== 1'b0) begin
            n_errors++; $display("FAIL exc_m: got %b want %b", obs, ex);
        end
        tick();
        W_stat = 4'h3;
        for (int i = 0; i < 70; i++) begin
            #2; ex = model_out();
            n_checks++;
            if (obs !== ex || stall_cnt !== CNT_W'(m_stall) || bubble_cnt !== CNT_W'(m_bub)) begin
                n_errors++;
                $display("FAIL exc_w cyc%0d: got %b cnt %0d/%0d want %b cnt %0d/%0d",
                    i, obs, stall_cnt, bubble_cnt, ex, m_stall, m_bub);
            end
            tick();
        end
        n_checks++;
        if (halted !== 1'b1 || W_stall !== 1'b1 || stall_cnt !== '1) begin
            n_errors++; $display("FAIL exc_saturate: got halted=%b W_stall=%b stall_cnt=%0d want 1 1 %0d",
                halted, W_stall, stall_cnt, MAXC);
        end
        set_idle();
    endtask

    task automatic test_random();
        logic [3:0] icodes [9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'hB};
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            reset    = ($urandom_range(0, 99) < 3);
            D_icode  = icodes[$urandom_range(0, 8)];
            E_icode  = icodes[$urandom_range(0, 8)];
            M_icode  = icodes[$urandom_range(0, 8)];
            d_srcA   = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            d_srcB   = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            E_dstM   = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            e_Cnd    = 1'($urandom_range(0, 1));
            dmem_ack = ($urandom_range(0, 2) == 0);
            M_stat   = ($urandom_range(0, 99) < 5) ? 4'($urandom_range(2, 4)) : 4'h1;
            W_stat   = ($urandom_range(0, 99) < 2) ? 4'($urandom_range(2, 4)) : 4'h1;
            #2; ex = model_out();
            n_checks++;
            if (obs !== ex || stall_cnt !== CNT_W'(m_stall) || bubble_cnt !== CNT_W'(m_bub)) begin
                n_errors++;
                $display("FAIL random cyc%0d: got %b cnt %0d/%0d want %b cnt %0d/%0d",
                    i, obs, stall_cnt, bubble_cnt, ex, m_stall, m_bub);
            end
            tick();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        tick();
        test_reset();
        test_load_use();
        test_ret();
        test_mispredict();
        test_mem_wait();
        test_timeout();
        test_exception();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
